gelu_row_arbiter: RTL and testbench
===================================

GELU_ROW_ARBITER -- requirements
Module: gelu_row_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4: number of requesters sharing one GELU row engine.
REQ-002 SHALL have parameter DIMENTION, default 64: elements per row.
REQ-003 SHALL have parameter x_WIDTH, default 8: input element width.
REQ-004 SHALL have parameter OUTPUT_WIDTH, default 8: output element width.
REQ-005 SHALL have parameter BURST_LEN, default 8: maximum rows per grant before rotation.
REQ-006 SHALL have parameter ENGINE_LAT, default 2: fixed engine latency, eng_x to eng_gelu, in cycles.
REQ-007 SHALL have one clock, clk_p, and an asynchronous active-low reset, rst_n.
REQ-008 clk_p  input  1  rising-edge clock.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 req_valid_n  input  REQ_NUM  per-requester row valid, active-low.
REQ-011 req_x  input  REQ_NUM*x_WIDTH*DIMENTION  per-requester row; slice i belongs to requester i.
REQ-012 req_ready  output  REQ_NUM  grant/accept strobe, active-high, at most one bit set.
REQ-013 eng_x  output  x_WIDTH*DIMENTION  row driven to the engine.
REQ-014 eng_valid_n  output  1  engine input valid, active-low.
REQ-015 eng_gelu  input  OUTPUT_WIDTH*DIMENTION  engine result row.
REQ-016 eng_gelu_valid_n  input  1  engine result valid, active-low.
REQ-017 rsp_gelu  output  OUTPUT_WIDTH*DIMENTION  shared result bus.
REQ-018 rsp_valid_n  output  REQ_NUM  per-requester result valid, active-low, at most one bit low.
REQ-019 busy  output  1  high while in BURST or any row is in flight.
REQ-020 err  output  1  sticky tag/engine mismatch flag.

Function
REQ-021 A transfer SHALL occur in a cycle where req_ready[g]=1 and req_valid_n[g]=0.
REQ-022 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-023 IDLE: pick the first i with req_valid_n[i]=0, searching round-robin from last_grant+1 modulo REQ_NUM; set g=i, last_grant=i, burst_cnt=0; enter BURST next cycle; req_ready=0 throughout IDLE.
REQ-024 BURST: req_ready[g]=1 combinationally; every transfer SHALL increment burst_cnt.
REQ-025 BURST SHALL return to IDLE after the transfer at burst_cnt=BURST_LEN-1, or in any cycle where req_valid_n[g]=1.
REQ-026 Every transfer SHALL register req_x slice g into eng_x with eng_valid_n=0 on the next cycle; otherwise eng_valid_n=1 and eng_x holds its value.
REQ-027 A tag pipeline of depth ENGINE_LAT SHALL carry {valid, g}, aligned with eng_valid_n.
REQ-028 When eng_gelu_valid_n=0 and the tag at the pipeline tail is valid, the next cycle SHALL have rsp_gelu=eng_gelu and rsp_valid_n[tag]=0; all other bits stay 1.
REQ-029 Total latency from transfer to rsp_valid_n SHALL be ENGINE_LAT+2 cycles (4 at defaults); there is no backpressure and requesters always accept.
REQ-030 An engine valid with no valid tail tag, or a valid tail tag with no engine valid, SHALL set err=1 until reset; no rsp_valid_n is asserted for that cycle.
REQ-031 Maximum throughput SHALL be one row per cycle within a burst, plus one IDLE bubble per grant.
REQ-032 A requester SHALL NOT be granted twice in a row while another requester is waiting.

Reset
REQ-033 On rst_n=0, immediately: FSM=IDLE, last_grant=REQ_NUM-1 so requester 0 has priority, burst_cnt=0, tags invalid.
REQ-034 On rst_n=0, immediately: req_ready=0, eng_valid_n=1, eng_x=0, rsp_valid_n=all ones, rsp_gelu=0, busy=0, err=0.
REQ-035 Reset mid-burst SHALL drop in-flight rows, with no responses afterwards for them.

Structure
REQ-036 Package gelu_sched_pkg SHALL hold the FSM state enum and the default ENGINE_LAT and BURST_LEN constants.
REQ-037 The round-robin picker SHALL be one sub-module, gelu_rr_pick: request vector plus last_grant in, index plus found out, combinational.

Verification
REQ-038 After reset, req_valid_n=4'b1110 with 3 rows: req_ready[0] high 1 cycle after the request; rsp_valid_n[0] low at cycles 5, 6, 7; busy falls after the last row.
REQ-039 All four requesters continuously valid: grants rotate 0,1,2,3,0 with 8 transfers each and one idle cycle between grants.
REQ-040 Requester 2 drops valid after 3 rows, others idle: burst ends, and requester 2 re-requesting is granted again with no one waiting.
REQ-041 Engine model asserts eng_gelu_valid_n=0 with an empty tag pipeline: err=1, no rsp_valid_n asserted, err stays 1 until rst_n=0.
REQ-042 rst_n pulsed low mid-burst with 2 rows in flight: all outputs at reset values immediately, no responses afterwards, next grant goes to requester 0.

Source files
------------

// File: rtl/gelu_sched_pkg.sv
// Shared scheduling types and defaults for the GELU row arbiter.
// Holds the FSM state encoding, the default burst and engine-latency constants, and a width helper.
package gelu_sched_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } sched_state_e;

  localparam int DEF_ENGINE_LAT = 2;
  localparam int DEF_BURST_LEN  = 8;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gelu_rr_pick.sv
// Combinational round-robin picker.
// Returns the first active request after last_i, wrapping modulo REQ_NUM.
module gelu_rr_pick
  import gelu_sched_pkg::*;
#(
  parameter  int REQ_NUM = 4,
  localparam int IW      = idx_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [IW-1:0]      idx_o,
  output logic               found_o
);

  logic [IW-1:0] cand;

  // NOTE: every variable driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = IW'((int'(last_i) + k) % REQ_NUM);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/gelu_row_arbiter.sv
// Shares one fixed-latency GELU row engine among REQ_NUM requesters with round-robin bursts.
// Rows are tagged with their requester so each engine result is routed back on the shared bus.
module gelu_row_arbiter
  import gelu_sched_pkg::*;
#(
  parameter int REQ_NUM      = 4,
  parameter int DIMENTION    = 64,
  parameter int x_WIDTH      = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int ENGINE_LAT   = DEF_ENGINE_LAT
) (
  input  logic                                   clk_p,
  input  logic                                   rst_n,
  input  logic [REQ_NUM-1:0]                     req_valid_n,
  input  logic [REQ_NUM*x_WIDTH*DIMENTION-1:0]   req_x,
  output logic [REQ_NUM-1:0]                     req_ready,
  output logic [x_WIDTH*DIMENTION-1:0]           eng_x,
  output logic                                   eng_valid_n,
  input  logic [OUTPUT_WIDTH*DIMENTION-1:0]      eng_gelu,
  input  logic                                   eng_gelu_valid_n,
  output logic [OUTPUT_WIDTH*DIMENTION-1:0]      rsp_gelu,
  output logic [REQ_NUM-1:0]                     rsp_valid_n,
  output logic                                   busy,
  output logic                                   err
);

  localparam int IW   = idx_w(REQ_NUM);
  localparam int CW   = idx_w(BURST_LEN);
  localparam int XROW = x_WIDTH * DIMENTION;
  localparam int YROW = OUTPUT_WIDTH * DIMENTION;

  localparam logic [IW-1:0] LAST_REQ  = IW'(REQ_NUM - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  sched_state_e  state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;   // current grant, doubles as last_grant
  logic [CW-1:0] cnt_q, cnt_d;

  logic [REQ_NUM-1:0] req_act;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               xfer;

  assign req_act = ~req_valid_n;

  gelu_rr_pick #(
    .REQ_NUM (REQ_NUM)
  ) u_pick (
    .req_i   (req_act),
    .last_i  (grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    xfer      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_BURST;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      S_BURST: begin
        req_ready[grant_q] = 1'b1;
        xfer               = !req_valid_n[grant_q];
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= LAST_REQ;   // requester 0 wins the first search
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine launch register and tag pipeline
  // ---------------------------------------------------------------------------
  logic [XROW-1:0] eng_x_q;
  logic            eng_vn_q;
  logic [IW-1:0]   eng_g_q;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      eng_x_q  <= '0;
      eng_vn_q <= 1'b1;
      eng_g_q  <= '0;
    end else begin
      eng_vn_q <= !xfer;
      if (xfer) begin
        eng_x_q <= req_x[int'(grant_q)*XROW +: XROW];
        eng_g_q <= grant_q;
      end
    end
  end

  // Tail stage lines up with eng_gelu: ENGINE_LAT cycles after the row is on eng_x.
  logic [ENGINE_LAT-1:0] tag_vld_q;
  logic [IW-1:0]         tag_g_q [ENGINE_LAT];

  // NOTE: the tag id array is reset along with the valids; it is tiny and keeps X out of the response decode.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < ENGINE_LAT; i++) tag_g_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= !eng_vn_q;
      tag_g_q[0]   <= eng_g_q;
      for (int i = 1; i < ENGINE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_g_q[i]   <= tag_g_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing and error tracking
  // ---------------------------------------------------------------------------
  logic               tail_vld;
  logic [IW-1:0]      tail_g;
  logic               eng_hit;
  logic               rsp_fire;
  logic [REQ_NUM-1:0] rsp_vn_d, rsp_vn_q;
  logic [YROW-1:0]    rsp_gelu_q;
  logic               err_q;

  assign tail_vld = tag_vld_q[ENGINE_LAT-1];
  assign tail_g   = tag_g_q[ENGINE_LAT-1];
  assign eng_hit  = !eng_gelu_valid_n;
  assign rsp_fire = tail_vld && eng_hit;

  always_comb begin
    rsp_vn_d = '1;
    if (rsp_fire) rsp_vn_d[tail_g] = 1'b0;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vn_q   <= '1;
      rsp_gelu_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_vn_q <= rsp_vn_d;
      if (rsp_fire) rsp_gelu_q <= eng_gelu;
      // Either side arriving alone means the tag stream and engine disagree.
      if (tail_vld != eng_hit) err_q <= 1'b1;
    end
  end

  assign eng_x       = eng_x_q;
  assign eng_valid_n = eng_vn_q;
  assign rsp_gelu    = rsp_gelu_q;
  assign rsp_valid_n = rsp_vn_q;
  assign err         = err_q;
  assign busy        = (state_q == S_BURST) || !eng_vn_q || (|tag_vld_q);

endmodule

// File: tb/tb_gelu_row_arbiter.sv
// Self-checking bench for gelu_row_arbiter: table-driven cycle vectors plus directed multi-cycle sequences.
// The engine is modelled as an ENGINE_LAT-deep delay line that returns the bitwise inverse of each row.
module tb_gelu_row_arbiter;
  import gelu_sched_pkg::*;

  localparam int RN   = 4;
  localparam int DIM  = 64;
  localparam int XW   = 8;
  localparam int OW   = 8;
  localparam int LAT  = DEF_ENGINE_LAT;
  localparam int XROW = XW * DIM;
  localparam int YROW = OW * DIM;

  logic              clk_p = 1'b0;
  logic              rst_n = 1'b0;
  logic [RN-1:0]     req_valid_n = '1;
  logic [RN*XROW-1:0] req_x = '0;
  logic [RN-1:0]     req_ready;
  logic [XROW-1:0]   eng_x;
  logic              eng_valid_n;
  logic [YROW-1:0]   eng_gelu;
  logic              eng_gelu_valid_n;
  logic [YROW-1:0]   rsp_gelu;
  logic [RN-1:0]     rsp_valid_n;
  logic              busy;
  logic              err;

  logic inj  = 1'b0;   // force a stray engine valid
  logic drop = 1'b0;   // swallow real engine valids

  gelu_row_arbiter #(
    .REQ_NUM      (RN),
    .DIMENTION    (DIM),
    .x_WIDTH      (XW),
    .OUTPUT_WIDTH (OW),
    .BURST_LEN    (DEF_BURST_LEN),
    .ENGINE_LAT   (LAT)
  ) dut (
    .clk_p            (clk_p),
    .rst_n            (rst_n),
    .req_valid_n      (req_valid_n),
    .req_x            (req_x),
    .req_ready        (req_ready),
    .eng_x            (eng_x),
    .eng_valid_n      (eng_valid_n),
    .eng_gelu         (eng_gelu),
    .eng_gelu_valid_n (eng_gelu_valid_n),
    .rsp_gelu         (rsp_gelu),
    .rsp_valid_n      (rsp_valid_n),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk_p = ~clk_p;

  logic [XROW-1:0] mdl_x [LAT];
  logic [LAT-1:0]  mdl_vn;

  always @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      mdl_vn <= '1;
      for (int i = 0; i < LAT; i++) mdl_x[i] <= '0;
    end else begin
      mdl_x[0]  <= eng_x;
      mdl_vn[0] <= eng_valid_n;
      for (int i = 1; i < LAT; i++) begin
        mdl_x[i]  <= mdl_x[i-1];
        mdl_vn[i] <= mdl_vn[i-1];
      end
    end
  end

  assign eng_gelu         = ~mdl_x[LAT-1];
  assign eng_gelu_valid_n = inj ? 1'b0 : (drop | mdl_vn[LAT-1]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [YROW-1:0] act, input logic [7:0] b);
    logic [YROW-1:0] exp;
    exp = {DIM{b}};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got low word %0h expected every byte %0h", name, $time, act[63:0], b);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  // Asserts reset mid-cycle, checks every output immediately, releases one edge later.
  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid_n = '1;
    inj         = 1'b0;
    drop        = 1'b0;
    #1;
    check("rst_req_ready",   64'(req_ready),   64'(0));
    check("rst_eng_valid_n", 64'(eng_valid_n), 64'(1));
    check_row("rst_eng_x",   eng_x, 8'h00);
    check("rst_rsp_valid_n", 64'(rsp_valid_n), 64'hF);
    check_row("rst_rsp_gelu", rsp_gelu, 8'h00);
    check("rst_busy",        64'(busy),        64'(0));
    check("rst_err",         64'(err),         64'(0));
    step();
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [RN-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < RN; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct packed {
    logic       rst;
    logic [3:0] vn;
    logic [7:0] b;
    logic [3:0] ready;
    logic [3:0] rvn;
    logic [7:0] e;
    logic       evn;
    logic [7:0] ex;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  logic [RN-1:0] hist [64];
  logic [RN-1:0] exp_r, exp_rsp;
  int xfers [RN];

  initial begin
    // Three rows from requester 0 straight after reset.
    //                rst   vn       b      ready    rvn      e      evn   ex     busy
    tbl.push_back('{1'b1, 4'b1110, 8'h00, 4'b0000, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'b1110, 8'h11, 4'b0001, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1110, 8'h22, 4'b0001, 4'b1111, 8'h00, 1'b0, 8'h11, 1'b1});
    tbl.push_back('{1'b0, 4'b1110, 8'h33, 4'b0001, 4'b1111, 8'h00, 1'b0, 8'h22, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0001, 4'b1111, 8'h00, 1'b0, 8'h33, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1110, 8'hEE, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1110, 8'hDD, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1110, 8'hCC, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b0});
    // Requester 2 drops after three rows, then re-requests alone.
    tbl.push_back('{1'b1, 4'b1011, 8'h00, 4'b0000, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'b1011, 8'h41, 4'b0100, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 8'h42, 4'b0100, 4'b1111, 8'h00, 1'b0, 8'h41, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 8'h43, 4'b0100, 4'b1111, 8'h00, 1'b0, 8'h42, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0100, 4'b1111, 8'h00, 1'b0, 8'h43, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 8'h00, 4'b0000, 4'b1011, 8'hBE, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 8'h44, 4'b0100, 4'b1011, 8'hBD, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0100, 4'b1011, 8'hBC, 1'b0, 8'h44, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1111, 8'h00, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 8'h00, 4'b0000, 4'b1011, 8'hBB, 1'b1, 8'h00, 1'b0});

    step();
    foreach (tbl[k]) begin
      v = tbl[k];
      if (v.rst) do_reset();
      req_valid_n = v.vn;
      req_x       = {(RN*DIM){v.b}};
      #1;
      check("tbl_req_ready",   64'(req_ready),   64'(v.ready));
      check("tbl_rsp_valid_n", 64'(rsp_valid_n), 64'(v.rvn));
      check("tbl_eng_valid_n", 64'(eng_valid_n), 64'(v.evn));
      check("tbl_busy",        64'(busy),        64'(v.busy));
      check("tbl_err",         64'(err),         64'(0));
      if (!v.evn)        check_row("tbl_eng_x",    eng_x,    v.ex);
      if (v.rvn != 4'hF) check_row("tbl_rsp_gelu", rsp_gelu, v.e);
      step();
    end

    // All four requesters continuously valid: 8-row bursts rotating 0,1,2,3,0 with one idle cycle between.
    do_reset();
    req_valid_n = '0;
    for (int i = 0; i < RN; i++) begin
      req_x[i*XROW +: XROW] = {DIM{8'(8'hA0 + i)}};
      xfers[i] = 0;
    end
    for (int c = 0; c < 46; c++) begin
      exp_r   = (c % 9 == 0) ? '0 : RN'(1 << ((c / 9) % RN));
      hist[c] = exp_r;
      exp_rsp = (c >= LAT + 2) ? ~hist[c-LAT-2] : '1;
      #1;
      check("rot_req_ready",   64'(req_ready),   64'(exp_r));
      check("rot_rsp_valid_n", 64'(rsp_valid_n), 64'(exp_rsp));
      if (exp_rsp != '1) check_row("rot_rsp_gelu", rsp_gelu, ~(8'(8'hA0 + oh_idx(~exp_rsp))));
      for (int i = 0; i < RN; i++) if (req_ready[i]) xfers[i]++;
      step();
    end
    for (int i = 0; i < RN; i++) check("rot_xfer_count", 64'(xfers[i]), (i == 0) ? 64'd16 : 64'd8);
    req_valid_n = '1;

    // Stray engine valid with an empty tag pipeline.
    do_reset();
    inj = 1'b1;
    #1;
    check("stray_err_before", 64'(err), 64'(0));
    step();
    inj = 1'b0;
    #1;
    check("stray_err",         64'(err),         64'(1));
    check("stray_rsp_valid_n", 64'(rsp_valid_n), 64'hF);
    repeat (5) step();
    #1;
    check("stray_err_sticky", 64'(err), 64'(1));
    step();

    // Valid tail tag with the engine result swallowed.
    do_reset();
    drop        = 1'b1;
    req_valid_n = 4'b1101;
    req_x       = {(RN*DIM){8'h77}};
    step();
    step();
    req_valid_n = '1;
    step();
    step();
    #1;
    check("lost_err_before",    64'(err),         64'(0));
    step();
    #1;
    check("lost_err",           64'(err),         64'(1));
    check("lost_rsp_valid_n",   64'(rsp_valid_n), 64'hF);
    step();
    drop = 1'b0;

    // Reset with two rows in flight, mid-burst.
    do_reset();
    req_valid_n = 4'b1110;
    req_x       = {(RN*DIM){8'h5A}};
    step();
    step();
    step();
    check("mid_eng_valid_n", 64'(eng_valid_n), 64'(0));
    check("mid_busy",        64'(busy),        64'(1));
    do_reset();
    for (int c = 0; c < 8; c++) begin
      #1;
      check("post_rst_rsp_valid_n", 64'(rsp_valid_n), 64'hF);
      check("post_rst_err",         64'(err),         64'(0));
      check("post_rst_busy",        64'(busy),        64'(0));
      step();
    end
    req_valid_n = '0;
    step();
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b0001);
    req_valid_n = '1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1);
  end

endmodule
